// File: rtl/i2c_master_word_adapter.sv
// Splits processor words into I2C driver bytes (MSB first) and assembles read bytes back into words.
// Optional watchdog enabled by defining I2C_WORD_ADAPTER_TIMEOUT_EN.
module i2c_master_word_adapter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned I2C_DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_rw,
  input  logic [DATA_WIDTH-1:0]     req_word,
  output logic                      start_transaction,
  output logic                      rw,
  input  logic                      drv_ready,
  output logic [I2C_DATA_WIDTH-1:0] drv_data_in,
  input  logic [I2C_DATA_WIDTH-1:0] drv_data_out,
  output logic [DATA_WIDTH-1:0]     rd_word,
  output logic                      done,
  output logic                      error
);

  localparam int unsigned N  = DATA_WIDTH / I2C_DATA_WIDTH;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] XFER  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic                  rdy_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] shifted_in;
  logic                  rise;
  logic                  fall;
  logic                  last_byte;

  assign rise       = drv_ready & ~rdy_q;
  assign fall       = ~drv_ready & rdy_q;
  assign last_byte  = (cnt == CW'(N - 1));
  assign shifted_in = (word_q << I2C_DATA_WIDTH) | DATA_WIDTH'(drv_data_out);

  assign req_ready         = (state == IDLE);
  assign start_transaction = (state == START);
  assign done              = (state == DONE);

`ifdef I2C_WORD_ADAPTER_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd;
  logic          err_q;
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rdy_q       <= 1'b0;
      word_q      <= '0;
      rw          <= 1'b0;
      drv_data_in <= '0;
      rd_word     <= '0;
`ifdef I2C_WORD_ADAPTER_TIMEOUT_EN
      wd          <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      rdy_q <= drv_ready;
      case (state)
        IDLE: begin
          if (req_valid) begin
            word_q <= req_word;
            rw     <= req_rw;
            cnt    <= '0;
            state  <= START;
`ifdef I2C_WORD_ADAPTER_TIMEOUT_EN
            wd     <= '0;
            err_q  <= 1'b0;
`endif
          end
        end
        START: state <= XFER;
        XFER: begin
          if (rise && cnt < CW'(N)) begin
            cnt <= cnt + 1'b1;
            if (!rw) begin
              drv_data_in <= word_q[DATA_WIDTH-1 -: I2C_DATA_WIDTH];
              word_q      <= word_q << I2C_DATA_WIDTH;
              if (last_byte) state <= DRAIN;
            end else begin
              word_q <= shifted_in;
              // Loaded on entry to DONE so rd_word is valid while done is high.
              if (last_byte) begin
                rd_word <= shifted_in;
                state   <= DONE;
              end
            end
          end
        end
        DRAIN: if (fall) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef I2C_WORD_ADAPTER_TIMEOUT_EN
      if (state == START || state == XFER || state == DRAIN) begin
        if (rise || fall) begin
          wd <= '0;
        end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
          err_q <= 1'b1;
          state <= IDLE;
        end else begin
          wd <= wd + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_i2c_master_word_adapter.sv
// Self-checking bench for i2c_master_word_adapter: directed scenarios plus random word transfers.
module tb_i2c_master_word_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [31:0] req_word;
  logic        start_transaction;
  logic        rw;
  logic        drv_ready;
  logic [7:0]  drv_data_in;
  logic [7:0]  drv_data_out;
  logic [31:0] rd_word;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  logic [31:0] exp_rd = '0;

  i2c_master_word_adapter #(
    .DATA_WIDTH(32),
    .I2C_DATA_WIDTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rw(req_rw),
    .req_word(req_word),
    .start_transaction(start_transaction),
    .rw(rw),
    .drv_ready(drv_ready),
    .drv_data_in(drv_data_in),
    .drv_data_out(drv_data_out),
    .rd_word(rd_word),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (start_transaction) start_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return w[8*(3-i) +: 8];
  endfunction

  task automatic issue(input logic r, input logic [31:0] w);
    @(negedge clk);
    req_valid = 1'b1; req_rw = r; req_word = w;
    @(negedge clk);
    req_valid = 1'b0; req_word = $urandom;
    check("start_hi", start_transaction, 1);
    check("rw_out", rw, r);
    check("err_clr", error, 0);
    @(negedge clk);
    check("start_lo", start_transaction, 0);
  endtask

  // One driver handshake: drv_data_out presented with the rise, write byte checked one cycle later.
  task automatic pulse(input logic r, input logic [31:0] w, input logic [31:0] rdata, input int i,
                       input bit busy_poke);
    drv_data_out = byte_of(rdata, i);
    drv_ready = 1'b1;
    @(negedge clk);
    if (!r) check("wr_byte", drv_data_in, byte_of(w, i));
    if (busy_poke) begin
      req_valid = 1'b1; req_rw = ~r; req_word = 32'hDEADBEEF;
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    req_valid = 1'b0;
    drv_ready = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    check("idle", req_ready, 1);
  endtask

  task automatic xact(input logic r, input logic [31:0] w, input logic [31:0] rdata, input bit busy);
    int d0;
    int s0;
    d0 = done_cnt;
    s0 = start_cnt;
    issue(r, w);
    for (int i = 0; i < 4; i++) pulse(r, w, rdata, i, busy && i == 1);
    wait_idle();
    check("done_once", done_cnt - d0, 1);
    check("start_once", start_cnt - s0, 1);
    if (r) exp_rd = rdata;
    check("rd_word", rd_word, exp_rd);
  endtask

  task automatic stray_pulse();
    @(negedge clk);
    drv_ready = 1'b1;
    @(negedge clk);
    drv_ready = 1'b0;
    @(negedge clk);
    check("stray_idle", req_ready, 1);
  endtask

  initial begin
    int d0;
    rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_word = '0;
    drv_ready = 1'b0; drv_data_out = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_start", start_transaction, 0);
    check("rst_rw", rw, 0);
    check("rst_din", drv_data_in, 0);
    check("rst_rd", rd_word, 0);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    rst = 1'b0;

    xact(1'b0, 32'hA1B1C1D1, $urandom, 1'b0);
    xact(1'b1, $urandom, 32'hA2B2C2D2, 1'b0);
    xact(1'b0, 32'h11223344, $urandom, 1'b0);
    xact(1'b1, $urandom, 32'hA2B2C2D2, 1'b0);
    check("b2b_rd", rd_word, 32'hA2B2C2D2);

    xact(1'b0, 32'h5A6B7C8D, $urandom, 1'b1);
    stray_pulse();
    xact(1'b1, $urandom, 32'hCAFEF00D, 1'b1);
    stray_pulse();

    // Reset in the middle of a read
    d0 = done_cnt;
    issue(1'b1, $urandom);
    pulse(1'b1, '0, 32'h99887766, 0, 1'b0);
    pulse(1'b1, '0, 32'h99887766, 1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_rd", rd_word, 0);
    rst = 1'b0;
    exp_rd = '0;
    check("mid_rst_nodone", done_cnt - d0, 0);
    xact(1'b1, $urandom, 32'h01020304, 1'b0);

    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 3) == 0) stray_pulse();
      xact(1'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    // Driver stalls after the first byte
    d0 = done_cnt;
    issue(1'b0, 32'h0BADF00D);
    pulse(1'b0, 32'h0BADF00D, '0, 0, 1'b0);
    repeat (8) @(negedge clk);
    check("stall_busy", req_ready, 0);
    check("stall_err_lo", error, 0);
`ifdef I2C_WORD_ADAPTER_TIMEOUT_EN
    for (int k = 0; k < 30 && !req_ready; k++) @(negedge clk);
    check("to_idle", req_ready, 1);
    check("to_err", error, 1);
    check("to_nodone", done_cnt - d0, 0);
    xact(1'b1, $urandom, 32'h0F1E2D3C, 1'b0);
`else
    repeat (40) @(negedge clk);
    check("noto_busy", req_ready, 0);
    check("noto_err", error, 0);
    check("noto_nodone", done_cnt - d0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rd = '0;
    xact(1'b1, $urandom, 32'h0F1E2D3C, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
